// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset release sequencer: state encoding,
// default timing parameters and the delay-counter width helper.
package reset_seq_pkg;

  localparam int DEF_STAGES      = 3;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_GAP_CYCLES  = 4;
  localparam int DEF_ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    RELEASE  = 3'd1,
    WAIT_ACK = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  // One counter serves all timed states, so it is sized for the longest interval.
  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Up-counter with synchronous clear and enable; o_term flags count == i_limit.
module seq_delay_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_term
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_term = (r_count == i_limit);

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases STAGES reset domains in order with hold, per-stage ack/timeout and gaps.
// Optional one-shot stage_pulse output when RESET_SEQ_STAGE_PULSE_EN is defined.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart_req,
  input  logic [STAGES-1:0]       stage_ack,
  output logic [STAGES-1:0]       stage_rst_n,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [$clog2(STAGES):0] cur_stage
`ifdef RESET_SEQ_STAGE_PULSE_EN
  ,
  output logic [STAGES-1:0]       stage_pulse
`endif
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam int SW = $clog2(STAGES) + 1;

  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LIM  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [STAGES-1:0] r_stage_rst_n;
  logic [STAGES-1:0] w_stage_rst_n_next;
  logic [SW-1:0]     r_cur_stage;
  logic [SW-1:0]     w_cur_stage_next;
  logic [STAGES-1:0] w_stage_sel;
  logic              w_ack_cur;
  logic [CW-1:0]     w_limit;
  logic              w_cnt_en;
  logic              w_cnt_clr;
  logic              w_term;

  // One-hot view of cur_stage, used both to pick the ack and to set the release bit.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_sel
    assign w_stage_sel[gi] = (r_cur_stage == SW'(gi));
  end

  assign w_ack_cur = |(stage_ack & w_stage_sel);

  always_comb begin
    w_limit  = '0;
    w_cnt_en = 1'b0;
    case (r_state)
      HOLD:     begin w_limit = HOLD_LIM; w_cnt_en = 1'b1; end
      WAIT_ACK: begin w_limit = ACK_LIM;  w_cnt_en = 1'b1; end
      GAP:      begin w_limit = GAP_LIM;  w_cnt_en = 1'b1; end
      default:  begin w_limit = '0;       w_cnt_en = 1'b0; end
    endcase
  end

  assign w_cnt_clr = (w_state_next != r_state);

  seq_delay_counter #(
    .WIDTH(CW)
  ) u_delay_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_limit(w_limit),
    .o_term (w_term)
  );

  always_comb begin
    w_state_next       = r_state;
    w_stage_rst_n_next = r_stage_rst_n;
    w_cur_stage_next   = r_cur_stage;
    case (r_state)
      HOLD: begin
        if (w_term) begin
          w_state_next     = RELEASE;
          w_cur_stage_next = '0;
        end
      end
      RELEASE: begin
        w_stage_rst_n_next = r_stage_rst_n | w_stage_sel;
        w_state_next       = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack on the timeout edge still counts as success.
        if (w_ack_cur) begin
          if (r_cur_stage == LAST_STAGE) begin
            w_state_next = DONE;
          end else if (GAP_CYCLES == 0) begin
            w_state_next     = RELEASE;
            w_cur_stage_next = r_cur_stage + SW'(1);
          end else begin
            w_state_next = GAP;
          end
        end else if (w_term) begin
          w_state_next = ERROR;
        end
      end
      GAP: begin
        if (w_term) begin
          w_state_next     = RELEASE;
          w_cur_stage_next = r_cur_stage + SW'(1);
        end
      end
      DONE, ERROR: begin
        if (restart_req) begin
          w_state_next       = HOLD;
          w_stage_rst_n_next = '0;
          w_cur_stage_next   = '0;
        end
      end
      default: begin
        w_state_next       = HOLD;
        w_stage_rst_n_next = '0;
        w_cur_stage_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HOLD;
      r_stage_rst_n <= '0;
      r_cur_stage   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_stage_rst_n <= w_stage_rst_n_next;
      r_cur_stage   <= w_cur_stage_next;
    end
  end

  assign stage_rst_n = r_stage_rst_n;
  assign cur_stage   = r_cur_stage;
  assign done        = (r_state == DONE);
  assign timeout_err = (r_state == ERROR);
  assign busy        = (r_state != DONE) && (r_state != ERROR);

`ifdef RESET_SEQ_STAGE_PULSE_EN
  logic [STAGES-1:0] r_stage_pulse;

  // Fires on the same edge a stage_rst_n bit goes 0 -> 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_pulse <= '0;
    end else begin
      r_stage_pulse <= w_stage_rst_n_next & ~r_stage_rst_n;
    end
  end

  assign stage_pulse = r_stage_pulse;
`endif

endmodule
